// File: rtl/cpu_types_pkg.sv
// Shared types for the LL/SC responder.
// Word/word-address types and responder FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [29:0] waddr_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } llsc_state_t;

   function automatic waddr_t word_addr(input word_t a);
      return a[31:2];
   endfunction

endpackage

// File: rtl/reservation_reg.sv
// Load-linked reservation: one word address plus valid bit.
// Set has priority over clear so an LL beats a same-cycle snoop.
module reservation_reg
   import cpu_types_pkg::*;
(
   input  logic   CLK,
   input  logic   nRST,
   input  logic   set,
   input  logic   clr,
   input  waddr_t setaddr,
   input  waddr_t cmpaddr,
   output logic   match,
   output logic   valid,
   output waddr_t linkaddr
);

   logic   valid_q, valid_d;
   waddr_t addr_q, addr_d;

   // next link state: set wins over clear
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (set) begin
         valid_d = 1'b1;
         addr_d  = setaddr;
      end else if (clr) begin
         valid_d = 1'b0;
      end
   end

   // link registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign match    = valid_q && (addr_q == cmpaddr);
   assign valid    = valid_q;
   assign linkaddr = addr_q;

endmodule

// File: rtl/llsc_responder.sv
// Datapath-to-cache responder with LL/SC link tracking.
// All outputs come from registers; no chit->dhit path.
module llsc_responder
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  dmemREN,
   input  logic  dmemWEN,
   input  logic  datomic,
   input  word_t dmemaddr,
   input  word_t dmemstore,
   output logic  dhit,
   output word_t dmemload,
   output logic  cREN,
   output logic  cWEN,
   output word_t caddr,
   output word_t cstore,
   input  logic  chit,
   input  word_t cload,
   input  logic  snoopinv,
   input  word_t snoopaddr
);

   llsc_state_t state_q, state_d;
   word_t       addr_q, addr_d;
   word_t       store_q, store_d;
   word_t       load_q, load_d;
   logic        atomic_q, atomic_d;
   logic        ren_q, ren_d;
   logic        wen_q, wen_d;
   logic        dhit_q, dhit_d;
   logic        cren_q, cren_d;
   logic        cwen_q, cwen_d;

   logic   link_set, link_clr;
   logic   link_match, link_valid;
   waddr_t link_addr;
   logic   snoop_hit, sc_ok;

   reservation_reg u_resv (
      .CLK      (CLK),
      .nRST     (nRST),
      .set      (link_set),
      .clr      (link_clr),
      .setaddr  (word_addr(addr_q)),
      .cmpaddr  (word_addr(dmemaddr)),
      .match    (link_match),
      .valid    (link_valid),
      .linkaddr (link_addr)
   );

   // next-state, latched request and link control
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      store_d  = store_q;
      load_d   = load_q;
      atomic_d = atomic_q;
      ren_d    = ren_q;
      wen_d    = wen_q;
      dhit_d   = dhit_q;
      cren_d   = cren_q;
      cwen_d   = cwen_q;
      snoop_hit = snoopinv &&
                  (word_addr(snoopaddr) == link_addr);
      sc_ok    = link_valid && link_match && !snoop_hit;
      link_set = 1'b0;
      link_clr = snoop_hit;
      unique case (state_q)
         IDLE: begin
            dhit_d = 1'b0;
            if (dmemREN || dmemWEN) begin
               addr_d   = dmemaddr;
               store_d  = dmemstore;
               atomic_d = datomic;
               ren_d    = dmemREN;
               wen_d    = !dmemREN;
               if (datomic && !dmemREN && !sc_ok) begin
                  state_d  = RESP;
                  dhit_d   = 1'b1;
                  load_d   = '0;
                  link_clr = 1'b1;
               end else begin
                  state_d = ACCESS;
                  cren_d  = dmemREN;
                  cwen_d  = !dmemREN;
               end
            end
         end
         ACCESS: begin
            if (chit) begin
               state_d = RESP;
               cren_d  = 1'b0;
               cwen_d  = 1'b0;
               dhit_d  = 1'b1;
               if (ren_q)
                  load_d = cload;
               else if (atomic_q)
                  load_d = 32'd1;
               else
                  load_d = '0;
               if (ren_q && atomic_q)
                  link_set = 1'b1;
               if (wen_q && atomic_q)
                  link_clr = 1'b1;
               if (wen_q && !atomic_q &&
                   word_addr(addr_q) == link_addr)
                  link_clr = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            dhit_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            dhit_d  = 1'b0;
            cren_d  = 1'b0;
            cwen_d  = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         store_q  <= '0;
         load_q   <= '0;
         atomic_q <= 1'b0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         dhit_q   <= 1'b0;
         cren_q   <= 1'b0;
         cwen_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         load_q   <= load_d;
         atomic_q <= atomic_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         dhit_q   <= dhit_d;
         cren_q   <= cren_d;
         cwen_q   <= cwen_d;
      end
   end

   assign dhit     = dhit_q;
   assign dmemload = load_q;
   assign cREN     = cren_q;
   assign cWEN     = cwen_q;
   assign caddr    = addr_q;
   assign cstore   = store_q;

endmodule

// File: tb/tb_llsc_responder.sv
// Directed-vector bench for llsc_responder.
// Each table row is one cycle of inputs plus expected registered outputs.
module tb_llsc_responder;

   localparam int NO = 0;
   localparam int RD = 1;
   localparam int WR = 2;
   localparam int LL = 3;
   localparam int SC = 4;
   localparam int RW = 5;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN, datomic;
   logic [31:0] dmemaddr, dmemstore;
   logic        dhit;
   logic [31:0] dmemload;
   logic        cREN, cWEN;
   logic [31:0] caddr, cstore;
   logic        chit;
   logic [31:0] cload;
   logic        snoopinv;
   logic [31:0] snoopaddr;

   int ncmp = 0;
   int nbad = 0;

   typedef struct {
      int          op;
      logic [31:0] addr;
      logic [31:0] st;
      logic        chit;
      logic [31:0] cload;
      logic        sinv;
      logic [31:0] saddr;
      logic        dhit;
      logic [31:0] load;
      logic        cren;
      logic        cwen;
      logic [31:0] caddr;
      logic [31:0] cstore;
      logic        lv;
   } vec_t;

   vec_t tbl[$];

   llsc_responder dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .dmemREN   (dmemREN),
      .dmemWEN   (dmemWEN),
      .datomic   (datomic),
      .dmemaddr  (dmemaddr),
      .dmemstore (dmemstore),
      .dhit      (dhit),
      .dmemload  (dmemload),
      .cREN      (cREN),
      .cWEN      (cWEN),
      .caddr     (caddr),
      .cstore    (cstore),
      .chit      (chit),
      .cload     (cload),
      .snoopinv  (snoopinv),
      .snoopaddr (snoopaddr)
   );

   always #5 CLK = ~CLK;

   task automatic row(
      input int op, input logic [31:0] addr, input logic [31:0] st,
      input logic ch, input logic [31:0] cl,
      input logic si, input logic [31:0] sa,
      input logic eh, input logic [31:0] ed,
      input logic er, input logic ew,
      input logic [31:0] ea, input logic [31:0] es,
      input logic el);
      vec_t t;
      t.op = op; t.addr = addr; t.st = st;
      t.chit = ch; t.cload = cl; t.sinv = si; t.saddr = sa;
      t.dhit = eh; t.load = ed; t.cren = er; t.cwen = ew;
      t.caddr = ea; t.cstore = es; t.lv = el;
      tbl.push_back(t);
   endtask

   task automatic drive(input int op, input logic [31:0] a,
                        input logic [31:0] s);
      dmemREN   = (op == RD || op == LL || op == RW);
      dmemWEN   = (op == WR || op == SC || op == RW);
      datomic   = (op == LL || op == SC);
      dmemaddr  = a;
      dmemstore = s;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      drive(NO, 0, 0);
      chit = 0; cload = 0; snoopinv = 0; snoopaddr = 0;

      // REQ-029: LL 0x100, chit on 2nd ACCESS cycle
      row(LL,'h100,0,     0,0,0,0, 0,0,1,0,'h100,0,0);
      row(NO,0,0,         0,0,0,0, 0,0,1,0,'h100,0,0);
      row(NO,0,0, 1,'hDEADBEEF,0,0, 1,'hDEADBEEF,0,0,'h100,0,1);
      row(NO,0,0,         0,0,0,0, 0,'hDEADBEEF,0,0,'h100,0,1);
      // REQ-030: SC 0x100 data 5 succeeds
      row(SC,'h100,5,     0,0,0,0, 0,'hDEADBEEF,0,1,'h100,5,1);
      row(NO,0,0,         1,0,0,0, 1,1,0,0,'h100,5,0);
      row(NO,0,0,         0,0,0,0, 0,1,0,0,'h100,5,0);
      // REQ-031a: snoop other word, SC succeeds
      row(LL,'h100,0,     0,0,0,0, 0,1,1,0,'h100,0,0);
      row(NO,0,0,      1,'h11,0,0, 1,'h11,0,0,'h100,0,1);
      row(NO,0,0,      0,0,1,'h104, 0,'h11,0,0,'h100,0,1);
      row(SC,'h100,'h22,  0,0,0,0, 0,'h11,0,1,'h100,'h22,1);
      row(NO,0,0,         1,0,0,0, 1,1,0,0,'h100,'h22,0);
      row(NO,0,0,         0,0,0,0, 0,1,0,0,'h100,'h22,0);
      // REQ-031b: snoop linked word, SC fails in 2 cycles
      row(LL,'h100,0,     0,0,0,0, 0,1,1,0,'h100,0,0);
      row(NO,0,0,      1,'h33,0,0, 1,'h33,0,0,'h100,0,1);
      row(NO,0,0,      0,0,1,'h100, 0,'h33,0,0,'h100,0,0);
      row(SC,'h100,'h44,  0,0,0,0, 1,0,0,0,'h100,'h44,0);
      row(NO,0,0,         0,0,0,0, 0,0,0,0,'h100,'h44,0);
      // snoop in the SC accept cycle also fails it
      row(LL,'h100,0,     0,0,0,0, 0,0,1,0,'h100,0,0);
      row(NO,0,0,      1,'h55,0,0, 1,'h55,0,0,'h100,0,1);
      row(NO,0,0,         0,0,0,0, 0,'h55,0,0,'h100,0,1);
      row(SC,'h100,'h50,0,0,1,'h100, 1,0,0,0,'h100,'h50,0);
      row(NO,0,0,         0,0,0,0, 0,0,0,0,'h100,'h50,0);
      // REQ-032a: SW to linked word kills SC
      row(LL,'h200,0,     0,0,0,0, 0,0,1,0,'h200,0,0);
      row(NO,0,0,      1,'h66,0,0, 1,'h66,0,0,'h200,0,1);
      row(NO,0,0,         0,0,0,0, 0,'h66,0,0,'h200,0,1);
      row(WR,'h200,'h77,  0,0,0,0, 0,'h66,0,1,'h200,'h77,1);
      row(NO,0,0,         1,0,0,0, 1,0,0,0,'h200,'h77,0);
      row(NO,0,0,         0,0,0,0, 0,0,0,0,'h200,'h77,0);
      row(SC,'h200,'h88,  0,0,0,0, 1,0,0,0,'h200,'h88,0);
      row(NO,0,0,         0,0,0,0, 0,0,0,0,'h200,'h88,0);
      // REQ-032b: SW to neighbour word keeps link
      row(LL,'h200,0,     0,0,0,0, 0,0,1,0,'h200,0,0);
      row(NO,0,0,      1,'h99,0,0, 1,'h99,0,0,'h200,0,1);
      row(NO,0,0,         0,0,0,0, 0,'h99,0,0,'h200,0,1);
      row(WR,'h204,'hAA,  0,0,0,0, 0,'h99,0,1,'h204,'hAA,1);
      row(NO,0,0,         1,0,0,0, 1,0,0,0,'h204,'hAA,1);
      row(NO,0,0,         0,0,0,0, 0,0,0,0,'h204,'hAA,1);
      row(SC,'h200,'hBB,  0,0,0,0, 0,0,0,1,'h200,'hBB,1);
      row(NO,0,0,         1,0,0,0, 1,1,0,0,'h200,'hBB,0);
      row(NO,0,0,         0,0,0,0, 0,1,0,0,'h200,'hBB,0);
      // REQ-033: snoop on LL chit cycle loses to the set
      row(LL,'h200,0,     0,0,0,0, 0,1,1,0,'h200,0,0);
      row(NO,0,0, 1,'hCC,1,'h200, 1,'hCC,0,0,'h200,0,1);
      row(NO,0,0,         0,0,0,0, 0,'hCC,0,0,'h200,0,1);
      row(SC,'h200,'hDD,  0,0,0,0, 0,'hCC,0,1,'h200,'hDD,1);
      row(NO,0,0,         1,0,0,0, 1,1,0,0,'h200,'hDD,0);
      row(NO,0,0,         0,0,0,0, 0,1,0,0,'h200,'hDD,0);
      // new LL overwrites old link
      row(LL,'h300,0,     0,0,0,0, 0,1,1,0,'h300,0,0);
      row(NO,0,0,       1,'h3,0,0, 1,'h3,0,0,'h300,0,1);
      row(NO,0,0,         0,0,0,0, 0,'h3,0,0,'h300,0,1);
      row(LL,'h400,0,     0,0,0,0, 0,'h3,1,0,'h400,0,1);
      row(NO,0,0,       1,'h4,0,0, 1,'h4,0,0,'h400,0,1);
      row(NO,0,0,         0,0,0,0, 0,'h4,0,0,'h400,0,1);
      row(SC,'h300,'hEE,  0,0,0,0, 1,0,0,0,'h300,'hEE,0);
      row(NO,0,0,         0,0,0,0, 0,0,0,0,'h300,'hEE,0);
      // REN and WEN together behave as a read
      row(RW,'h500,1,     0,0,0,0, 0,0,1,0,'h500,1,0);
      row(NO,0,0,    1,'h1234,0,0, 1,'h1234,0,0,'h500,1,0);
      row(NO,0,0,         0,0,0,0, 0,'h1234,0,0,'h500,1,0);

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst dhit", dhit, 0);
      chk("rst dmemload", dmemload, 0);
      chk("rst cREN", cREN, 0);
      chk("rst cWEN", cWEN, 0);
      chk("rst caddr", caddr, 0);
      chk("rst cstore", cstore, 0);
      chk("rst link", dut.u_resv.valid, 0);
      nRST = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].addr, tbl[i].st);
         chit      = tbl[i].chit;
         cload     = tbl[i].cload;
         snoopinv  = tbl[i].sinv;
         snoopaddr = tbl[i].saddr;
         step();
         chk($sformatf("r%0d dhit", i), dhit, tbl[i].dhit);
         chk($sformatf("r%0d dmemload", i), dmemload, tbl[i].load);
         chk($sformatf("r%0d cREN", i), cREN, tbl[i].cren);
         chk($sformatf("r%0d cWEN", i), cWEN, tbl[i].cwen);
         chk($sformatf("r%0d caddr", i), caddr, tbl[i].caddr);
         chk($sformatf("r%0d cstore", i), cstore, tbl[i].cstore);
         chk($sformatf("r%0d link", i), dut.u_resv.valid, tbl[i].lv);
      end
      drive(NO, 0, 0);
      chit = 0; snoopinv = 0;

      // REQ-034: reset in the middle of an LL access
      drive(LL, 'h100, 0);
      step();
      drive(NO, 0, 0);
      chit = 1; cload = 'h7;
      step();
      chk("pre-rst link", dut.u_resv.valid, 1);
      chit = 0;
      step();
      drive(LL, 'h100, 0);
      step();
      chk("pre-rst cREN", cREN, 1);
      drive(NO, 0, 0);
      #2 nRST = 1'b0;
      #1;
      chk("mid-rst cREN", cREN, 0);
      chk("mid-rst dhit", dhit, 0);
      chk("mid-rst caddr", caddr, 0);
      chk("mid-rst dmemload", dmemload, 0);
      chk("mid-rst link", dut.u_resv.valid, 0);
      #3 nRST = 1'b1;
      chit = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post-rst dhit%0d", k), dhit, 0);
         chk($sformatf("post-rst cREN%0d", k), cREN, 0);
      end
      chit = 0;
      drive(SC, 'h100, 'h9);
      step();
      chk("post-rst sc dhit", dhit, 1);
      chk("post-rst sc load", dmemload, 0);
      chk("post-rst sc cWEN", cWEN, 0);
      drive(NO, 0, 0);
      step();
      chk("post-rst sc end", dhit, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nbad);
      $finish;
   end

endmodule
